// File: rtl/operand_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | operand_loader_if : nibble handshake in, operand word/tracking out    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface operand_loader_if;
  logic [3:0]  nib_in;
  logic        nib_valid;
  logic        nib_ready;
  logic        flush;
  logic [23:0] word_out;
  logic        word_valid;
  logic        div_zero;
  logic        res_valid;
  logic        res_divz;

  modport master (
    output nib_in, nib_valid, flush,
    input  nib_ready, word_out, word_valid, div_zero, res_valid, res_divz
  );

  modport slave (
    input  nib_in, nib_valid, flush,
    output nib_ready, word_out, word_valid, div_zero, res_valid, res_divz
  );
endinterface
`default_nettype wire

// File: rtl/operand_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | operand_loader : assembles six nibbles into a 24-bit operand word and |
// | flags which 3-cycle-later pipeline outputs carry real results.        |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module operand_loader (
  input  logic              clk,
  input  logic              reset,
  operand_loader_if.slave   bus
);

  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam logic [2:0] C_LAST_NIB = 3'd5;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_accept;
  logic [23:0] w_next_word;
  logic [23:0] r_asm;
  logic [2:0]  r_count;
  logic [2:0]  r_vpipe;
  logic [2:0]  r_zpipe;

  assign w_next_word = {r_asm[19:0], bus.nib_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= LOAD;
    else       r_state <= w_state_next;
  end

  // flush beats acceptance, so a nibble offered with flush is dropped
  always_comb begin
    w_state_next  = r_state;
    bus.nib_ready = 1'b0;
    w_accept      = 1'b0;
    unique case (r_state)
      LOAD: begin
        bus.nib_ready = !reset;
        w_accept      = bus.nib_valid && !bus.flush;
        if (w_accept && (r_count == C_LAST_NIB))
          w_state_next = ISSUE;
      end
      ISSUE: w_state_next = LOAD;
      default: w_state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_asm          <= 24'd0;
      r_count        <= 3'd0;
      r_vpipe        <= 3'd0;
      r_zpipe        <= 3'd0;
      bus.word_out   <= 24'd0;
      bus.word_valid <= 1'b0;
      bus.div_zero   <= 1'b0;
    end else begin
      r_vpipe        <= {r_vpipe[1:0], bus.word_valid};
      r_zpipe        <= {r_zpipe[1:0], bus.word_valid & bus.div_zero};
      bus.word_valid <= 1'b0;
      if (r_state == LOAD) begin
        if (bus.flush) begin
          r_count <= 3'd0;
        end else if (w_accept) begin
          r_asm <= w_next_word;
          if (r_count == C_LAST_NIB) begin
            r_count        <= 3'd0;
            bus.word_out   <= w_next_word;
            bus.word_valid <= 1'b1;
            // divisors are b, d and f
            bus.div_zero   <= (w_next_word[19:16] == 4'd0) ||
                              (w_next_word[11:8]  == 4'd0) ||
                              (w_next_word[3:0]   == 4'd0);
          end else begin
            r_count <= r_count + 3'd1;
          end
        end
      end
    end
  end

  assign bus.res_valid = r_vpipe[2];
  assign bus.res_divz  = r_zpipe[2];

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// Testbench for operand_loader: directed scenarios plus random traffic checked
// against a nibble-queue reference model and a behavioural arithmetic pipeline.
module tb_operand_loader;

  logic clk;
  logic reset;
  operand_loader_if bus ();

  operand_loader u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // behavioural divide/multiply/subtract pipeline: (a/b)*(c/d) - e/f, 3 registers
  function automatic int pipe_eval(input logic [23:0] w);
    int a, b, c, d, e, f, q1, q2, q3;
    a = w[23:20]; b = w[19:16]; c = w[15:12];
    d = w[11:8];  e = w[7:4];   f = w[3:0];
    q1 = (b == 0) ? 0 : a / b;
    q2 = (d == 0) ? 0 : c / d;
    q3 = (f == 0) ? 0 : e / f;
    return q1 * q2 - q3;
  endfunction

  logic [23:0] pipe_s0, pipe_s1;
  int          pipe_out;
  always @(posedge clk) begin
    pipe_s0  <= bus.word_out;
    pipe_s1  <= pipe_s0;
    pipe_out <= pipe_eval(pipe_s1);
  end

  // reference model state
  int          cyc = 0;
  int          m_nibs[$];
  bit          m_issuing = 0;
  logic [23:0] m_word = '0;
  bit          m_dz = 0;
  bit          issued_at[int];
  bit          dz_at[int];
  int          exp_pipe = -1;
  int          wv_times[$];
  int          rv_times[$];

  task automatic cycle(input logic v, input logic [3:0] n, input logic f);
    bit exp_rv, exp_rz;
    bus.nib_valid = v;
    bus.nib_in    = n;
    bus.flush     = f;
    #1;
    exp_rv = issued_at.exists(cyc - 3);
    exp_rz = exp_rv ? dz_at[cyc - 3] : 1'b0;
    check_eq("nib_ready",  bus.nib_ready,  !m_issuing);
    check_eq("word_valid", bus.word_valid, m_issuing);
    check_eq("word_out",   bus.word_out,   m_word);
    check_eq("div_zero",   bus.div_zero,   m_dz);
    check_eq("res_valid",  bus.res_valid,  exp_rv);
    check_eq("res_divz",   bus.res_divz,   exp_rz);
    if (exp_rv && exp_pipe >= 0) check_eq("pipe_out", pipe_out, exp_pipe);
    if (bus.word_valid) wv_times.push_back(cyc);
    if (bus.res_valid)  rv_times.push_back(cyc);

    if (m_issuing) begin
      m_issuing = 0;
    end else if (f) begin
      m_nibs.delete();
    end else if (v) begin
      m_nibs.push_back(int'(n));
      if (m_nibs.size() == 6) begin
        m_word = '0;
        foreach (m_nibs[i]) m_word = (m_word << 4) | 24'(m_nibs[i]);
        m_dz = (m_nibs[1] == 0) || (m_nibs[3] == 0) || (m_nibs[5] == 0);
        m_issuing = 1;
        issued_at[cyc + 1] = 1'b1;
        dz_at[cyc + 1]     = m_dz;
        m_nibs.delete();
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.nib_valid = 1'b0;
    bus.flush     = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("rst_word_out",   bus.word_out,   24'd0);
    check_eq("rst_word_valid", bus.word_valid, 1'b0);
    check_eq("rst_div_zero",   bus.div_zero,   1'b0);
    check_eq("rst_res_valid",  bus.res_valid,  1'b0);
    check_eq("rst_res_divz",   bus.res_divz,   1'b0);
    check_eq("rst_nib_ready",  bus.nib_ready,  1'b0);
    m_nibs.delete();
    m_issuing = 0;
    m_word    = '0;
    m_dz      = 0;
    issued_at.delete();
    dz_at.delete();
    @(posedge clk);
    #4 reset = 1'b0;
    #1 check_eq("rel_nib_ready", bus.nib_ready, 1'b1);
    @(posedge clk);
    #1;
    cyc += 2;
  endtask

  task automatic send_word(input logic [23:0] w, input bit gaps);
    logic [23:0] t;
    t = w;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, t[23:20], 1'b0);
      t = t << 4;
      if (gaps && i < 5) cycle(1'b0, 4'h0, 1'b0);
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.nib_valid = 1'b0;
    bus.nib_in    = 4'h0;
    bus.flush     = 1'b0;
    #1;
    check_eq("init_word_out",  bus.word_out,  24'd0);
    check_eq("init_nib_ready", bus.nib_ready, 1'b0);
    check_eq("init_res_valid", bus.res_valid, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #4 reset = 1'b0;
    #1 check_eq("init_rel_ready", bus.nib_ready, 1'b1);
    @(posedge clk);
    #1;

    // scenario 1: 8,2,6,3,9,3 back to back
    exp_pipe = 5;
    wv_times.delete(); rv_times.delete();
    send_word(24'h826393, 1'b0);
    idle(5);
    check_eq("s1_word", bus.word_out, 24'h826393);
    check_eq("s1_wv_count", wv_times.size(), 1);
    check_eq("s1_rv_count", rv_times.size(), 1);
    if (wv_times.size() == 1 && rv_times.size() == 1)
      check_eq("s1_latency", rv_times[0] - wv_times[0], 3);
    exp_pipe = -1;

    // scenario 2: zero divisor
    send_word(24'h101111, 1'b0);
    idle(5);
    check_eq("s2_word", bus.word_out, 24'h101111);

    // scenario 3: alternate-cycle gaps
    wv_times.delete(); rv_times.delete();
    begin
      int first;
      first = cyc;
      send_word(24'h826393, 1'b1);
      idle(5);
      check_eq("s3_word", bus.word_out, 24'h826393);
      check_eq("s3_wv_count", wv_times.size(), 1);
      check_eq("s3_rv_count", rv_times.size(), 1);
      if (wv_times.size() == 1) check_eq("s3_wv_delay", wv_times[0] - first, 11);
    end

    // scenario 4: flush after three nibbles, with a valid 0xF alongside
    cycle(1'b1, 4'h1, 1'b0);
    cycle(1'b1, 4'h2, 1'b0);
    cycle(1'b1, 4'h4, 1'b0);
    cycle(1'b1, 4'hF, 1'b1);
    send_word(24'hA5C3E7, 1'b0);
    idle(5);
    check_eq("s4_word", bus.word_out, 24'hA5C3E7);

    // scenario 5: nib_valid held high over two full words
    wv_times.delete(); rv_times.delete();
    for (int i = 0; i < 14; i++) cycle(1'b1, 4'(i + 3), 1'b0);
    cycle(1'b0, 4'h0, 1'b0);
    idle(5);
    check_eq("s5_wv_count", wv_times.size(), 2);
    check_eq("s5_rv_count", rv_times.size(), 2);
    if (wv_times.size() == 2) check_eq("s5_wv_gap", wv_times[1] - wv_times[0], 7);
    if (rv_times.size() == 2) check_eq("s5_rv_gap", rv_times[1] - rv_times[0], 7);

    // scenario 6: reset after four nibbles, and one cycle after word_valid
    rv_times.delete();
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i + 7), 1'b0);
    do_reset();
    send_word(24'h826393, 1'b0);
    do_reset();
    idle(6);
    check_eq("s6_no_res", rv_times.size(), 0);
    send_word(24'h3579BD, 1'b0);
    idle(5);
    check_eq("s6_word", bus.word_out, 24'h3579BD);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else cycle(($urandom_range(0, 9) < 7), 4'($urandom), ($urandom_range(0, 19) == 0));
    end
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/operand_loader.md
# operand_loader

Front-end stage of the three-stage divide/multiply/subtract arithmetic pipeline. It accepts operands one 4-bit nibble at a time over a valid/ready handshake and assembles six nibbles (a, b, c, d, e, f) into the 24-bit operand word. It presents that word to the pipeline input with a single-cycle valid strobe. It tracks the strobe through the pipeline's fixed 3-cycle latency so consumers know which pipeline output cycle carries a real result, and whether that result involved a zero divisor.

## Interface
- No parameters; all widths are fixed by the pipeline (24-bit operand word, 4-bit nibbles, latency 3).
- clk  input  1  rising-edge clock, shared with the arithmetic pipeline
- reset  input  1  asynchronous, active-high reset
- nib_in  input  4  operand nibble
- nib_valid  input  1  nib_in is valid this cycle
- nib_ready  output  1  loader can accept a nibble this cycle
- flush  input  1  synchronous abort of a partially loaded word
- word_out  output  24  operand word {a,b,c,d,e,f}; a at [23:20], f at [3:0]; drives the pipeline input
- word_valid  output  1  one-cycle strobe: word_out holds a newly issued word
- div_zero  output  1  issued word has b, d or f equal to 0; qualified by word_valid
- res_valid  output  1  pipeline output carries the result of an issued word this cycle
- res_divz  output  1  div_zero of the word whose result is flagged by res_valid

## Operation
- Two states: LOAD and ISSUE. Reset enters LOAD.
- LOAD:
  - nib_ready = 1.
  - A nibble is accepted when nib_valid && nib_ready.
  - Accepted nibbles shift into a 24-bit assembly register: asm <= {asm[19:0], nib_in}. A 3-bit count increments per accepted nibble.
  - On the 6th accepted nibble (count == 5 at the accepting edge):
    - word_out <= {asm[19:0], nib_in}.
    - div_zero is computed on that value.
    - word_valid <= 1.
    - count <= 0.
    - State goes to ISSUE.
- ISSUE:
  - nib_ready = 0.
  - word_valid is high for exactly this one cycle.
  - Next edge: word_valid <= 0, state returns to LOAD.
- word_out only changes at issue. It holds the last issued word between issues; the pipeline re-samples it every cycle, but those results are not flagged.
- div_zero is registered with word_out and holds with it. It is meaningful only while word_valid = 1.
- flush:
  - In LOAD: count <= 0, state stays LOAD, the partial word is discarded, and any nibble offered in the same cycle is dropped (flush wins over acceptance).
  - In ISSUE: no effect. The issue completes.
- Latency tracking:
  - A 3-bit shift register advances every clock: vpipe <= {vpipe[1:0], word_valid}; zpipe <= {zpipe[1:0], word_valid & div_zero}.
  - res_valid = vpipe[2] and res_divz = zpipe[2] (both register outputs).
  - Tracking is independent of state and of flush.
- Reset values:
  - word_out = 0, word_valid = 0, div_zero = 0, res_valid = 0, res_divz = 0.
  - count = 0, asm = 0, vpipe = 0, zpipe = 0.
  - nib_ready is 0 while reset is asserted and 1 in the first cycle after release.

## Timing
- nib_ready is combinational from state only. It never depends on nib_valid.
- Minimum issue interval is 7 cycles (6 accepts + 1 ISSUE). Gaps in nib_valid stretch LOAD with no loss of state.
- Issue at cycle T (word_valid high during T):
  - The pipeline input register captures word_out at the end of T.
  - res_valid is high during cycle T+3 only.
- Back-to-back words at the maximum rate produce res_valid pulses exactly 7 cycles apart, with no overlap.
- Reset mid-operation clears the partial word and in-flight tracking at once. Results already inside the pipeline are never flagged.

## Test plan
- Nibbles 8,2,6,3,9,3 offered on consecutive cycles after reset:
  - word_valid pulses once with word_out = 0x826393, div_zero = 0.
  - res_valid = 1 and res_divz = 0 exactly 3 cycles later.
  - The pipeline out equals 5 in that cycle.
- Nibbles 1,0,1,1,1,1:
  - word_out = 0x101111, div_zero = 1.
  - res_valid and res_divz both high 3 cycles after word_valid.
- Same six nibbles as the first scenario, with nib_valid low on alternate cycles:
  - Identical word_out = 0x826393.
  - word_valid comes 11 cycles after the first accept.
  - Exactly one word_valid and one res_valid pulse.
- Three nibbles accepted, then flush asserted together with a valid nibble 0xF, then nibbles A,5,C,3,E,7:
  - word_out = 0xA5C3E7, with no trace of the first three nibbles or 0xF.
- nib_valid held high over two full words:
  - nib_ready low only in the ISSUE cycles.
  - word_valid pulses 7 cycles apart.
  - res_valid pulses 7 cycles apart.
- reset asserted asynchronously after 4 nibbles, and again one cycle after a word_valid:
  - All outputs return to 0 immediately.
  - No res_valid follows.
  - A fresh 6-nibble load afterwards issues correctly.
